rr_priority_arbiter: RTL and testbench
======================================

# rr_priority_arbiter

- Parametrised, registered successor to the combinational priority encoder.
- Arbitrates among `NUM_REQ` request lines with rotating (round-robin) priority, then presents a one-hot grant and its binary index through a valid/ready output stage.
- Sits between multiple requesters (e.g. issue slots, cache miss queues) and a shared resource.
- The granted index stays stable until the consumer accepts it.

## Interface
- `NUM_REQ`, 16, number of request lines; any value ≥ 1, power of two not required.
- `IDX_W`, `$clog2(NUM_REQ)` (minimum 1), width of `gnt_idx_o`.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  `NUM_REQ`  request vector; bit i = requester i wants the resource.
- `ready_i`  in  1  consumer accepts the current grant this cycle.
- `valid_o`  out  1  `gnt_o` / `gnt_idx_o` hold a valid grant.
- `gnt_o`  out  `NUM_REQ`  one-hot grant; all zeros when `valid_o`=0.
- `gnt_idx_o`  out  `IDX_W`  binary index of the granted line; 0 when `valid_o`=0.

## Operation
State:
- Output register: `valid_o`, `gnt_o`, `gnt_idx_o`.
- Priority pointer `ptr`, range 0..`NUM_REQ`-1.

Load rule:
- Stage is free when `valid_o`=0 or (`valid_o`=1 and `ready_i`=1).
- When free, the next edge loads a new arbitration result from the current `req_i`.
- Search order is `ptr`, `ptr`+1, …, `NUM_REQ`-1, 0, …, `ptr`-1. The first set bit wins.
- `req_i`=0 while free: next edge sets `valid_o`=0, `gnt_o`=0, `gnt_idx_o`=0.

Hold rule:
- `valid_o`=1 and `ready_i`=0: all outputs and `ptr` hold.
- `req_i` changes are ignored while holding, including deassertion of the granted line. The grant is registered and is not revoked.

Pointer update:
- Only on accept (`valid_o`=1 and `ready_i`=1).
- `ptr` ← `gnt_idx_o`+1, wrapping to 0 when `gnt_idx_o`=`NUM_REQ`-1. The wrap is explicit compare, not power-of-two masking.

Other rules:
- Accept and reload happen in the same cycle (back-to-back grants, full throughput).
- Invariants: `gnt_o` is one-hot or zero; `gnt_o`[`gnt_idx_o`]=1 whenever `valid_o`=1.
- `NUM_REQ`=1: `gnt_o` = `req_i` registered; `ptr` is constant 0.

## Timing
- Latency: `req_i` sampled at edge N appears on the outputs after edge N, i.e. 1 cycle.
- Reset: `rst_i`=1 at an edge forces `valid_o`=0, `gnt_o`=0, `gnt_idx_o`=0, `ptr`=0.
  - Reset overrides any pending handshake.
  - A grant pending mid-operation is discarded and not counted as accepted.
- First edge with `rst_i`=0 performs a normal load from `req_i`.
- Simultaneous accept and new requests: the new search uses the updated pointer value (`gnt_idx_o`+1), not the old `ptr`.
- Outputs are driven only from flops; no combinational path from `req_i`/`ready_i` to any output.

## Configuration
- Macro `RR_PRIORITY_ARBITER_ROUND_ROBIN_EN`.
- Defined: rotating priority as above.
- Undefined:
  - `ptr` logic is not compiled. The search always starts at index 0, so the lowest set index wins (fixed priority).
  - The handshake, hold and reset behaviour is identical to the defined case.

## Test plan
Settings for all scenarios: `NUM_REQ`=16; round-robin macro defined unless stated.

1. Reset then idle:
   - Stimulus: `rst_i`=1 for 2 cycles with `req_i`=16'hFFFF, then `req_i`=0, `ready_i`=1.
   - Required: `valid_o`=0, `gnt_o`=0, `gnt_idx_o`=0 throughout.
2. Rotation with wrap:
   - Stimulus: `req_i`=16'h1010 held, `ready_i`=1.
   - Required: `gnt_idx_o` sequence 4, 12, 4, 12, …; `gnt_o` 16'h0010 / 16'h1000; `valid_o` continuously 1 from the first cycle after reset release.
3. Backpressure hold:
   - Stimulus: grant idx 4 valid, `ready_i`=0 for 5 cycles while `req_i` changes to 16'h0002.
   - Required: `gnt_idx_o`=4 and `gnt_o`=16'h0010 stable for all 5 cycles.
   - After `ready_i`=1: next grant idx 1 (search from 5 wraps to 1).
4. Top-index wrap:
   - Stimulus: `req_i`=16'h8001.
   - Required: grants 0, 15, 0, 15 alternate; after accepting 15, `ptr`=0.
5. Reset mid-handshake:
   - Stimulus: `valid_o`=1 with `gnt_idx_o`=12, `ready_i`=0; assert `rst_i` for 1 cycle; then `req_i`=16'h1010.
   - Required: outputs clear, then grant idx 4 (`ptr` restarted at 0).
6. Macro undefined (fixed priority):
   - Stimulus: `req_i`=16'h1010 held, `ready_i`=1.
   - Required: `gnt_idx_o`=4 every cycle.
   - Also run 1000 random `req_i` cycles and check against a lowest-set-bit reference model.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// rr_priority_arbiter
//
// Registered arbiter over NUM_REQ request lines. Each time the output stage is
// free, it picks one requester and registers the result as a one-hot grant
// plus a binary index. The result is held behind a valid/ready handshake.
// A registered grant is never revoked. It stays on the outputs until the
// consumer accepts it, even if the requester drops its line.
//
// Optional feature macro: RR_PRIORITY_ARBITER_ROUND_ROBIN_EN
//   defined   : rotating priority. The search starts just after the last
//               accepted index.
//   undefined : fixed priority. The search always starts at index 0, so the
//               lowest set request wins. No pointer logic is built.
//
// Parameters:
//   NUM_REQ   number of request lines (>= 1, any value)
//   IDX_W     width of gnt_idx_o, $clog2(NUM_REQ) with a minimum of 1
//
// Ports:
//   clk_i      in   1        clock; everything updates on the rising edge
//   rst_i      in   1        synchronous active-high reset
//   req_i      in   NUM_REQ  request vector; bit i = requester i wants access
//   ready_i    in   1        consumer accepts the current grant this cycle
//   valid_o    out  1        gnt_o / gnt_idx_o hold a valid grant
//   gnt_o      out  NUM_REQ  one-hot grant; zero when valid_o = 0
//   gnt_idx_o  out  IDX_W    index of the granted line; zero when valid_o = 0
// -----------------------------------------------------------------------------
module rr_priority_arbiter #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Output stage registers and their next values.
  logic               valid_reg;
  logic               valid_next;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] gnt_next;
  logic [IDX_W-1:0]   gnt_idx_reg;
  logic [IDX_W-1:0]   gnt_idx_next;

  // Handshake decode.
  logic accept;       // current grant is consumed at this edge
  logic stage_free;   // output stage may load a new result at this edge

  // Arbitration search.
  logic [IDX_W-1:0] search_start;
  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;
  logic             lo_found;
  logic [IDX_W-1:0] lo_idx;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  assign accept     = valid_reg & ready_i;
  assign stage_free = ~valid_reg | ready_i;

`ifdef RR_PRIORITY_ARBITER_ROUND_ROBIN_EN
  // Rotating priority pointer. It only moves when a grant is accepted, and
  // then to the slot just after the accepted index. The wrap uses an explicit
  // compare so that NUM_REQ values that are not a power of two work.
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (accept) begin
      ptr_next = (gnt_idx_reg == LAST_IDX) ? '0 : gnt_idx_reg + IDX_W'(1);
    end
  end

  // An accept and a reload can happen in the same cycle. In that case the
  // reload must search from the updated pointer, so the search starts from
  // ptr_next rather than ptr_reg.
  assign search_start = ptr_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  assign search_start = '0;
`endif

  // Circular search in two linear passes. The search order is
  // start..NUM_REQ-1, then 0..start-1.
  //   hi pass: lowest set index at or above search_start.
  //   lo pass: lowest set index overall, used when the hi pass is empty.
  // The loops run downward, so the last hit (the lowest index) wins.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (i >= int'(search_start)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  // One-hot grant decoded from the winning index. When nothing is found the
  // grant is all zeros.
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt_onehot
    assign gnt_next[gi] = win_found && (win_idx == IDX_W'(gi));
  end

  assign valid_next   = win_found;
  assign gnt_idx_next = win_found ? win_idx : '0;

  // Output stage. It loads whenever free and holds otherwise. Reset takes
  // precedence over any pending handshake, and a grant dropped by reset is
  // never counted as accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg   <= 1'b0;
      gnt_reg     <= '0;
      gnt_idx_reg <= '0;
    end else if (stage_free) begin
      valid_reg   <= valid_next;
      gnt_reg     <= gnt_next;
      gnt_idx_reg <= gnt_idx_next;
    end
  end

  assign valid_o   = valid_reg;
  assign gnt_o     = gnt_reg;
  assign gnt_idx_o = gnt_idx_reg;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_priority_arbiter
//
// Self-checking bench for rr_priority_arbiter with NUM_REQ = 16.
// A behavioural model tracks the grant using modular arithmetic over the
// request vector. Its pointer only moves on accept. Every cycle the model is
// compared against valid_o, gnt_o and gnt_idx_o. Directed scenarios also
// check hand-derived constants.
//
// The bench follows RR_PRIORITY_ARBITER_ROUND_ROBIN_EN in the same way as the
// design. Rotating or fixed priority expectations are chosen from it.
// -----------------------------------------------------------------------------
module tb_rr_priority_arbiter;

  localparam int N  = 16;
  localparam int IW = 4;

`ifdef RR_PRIORITY_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_i;
  logic          ready_i;
  logic          valid_o;
  logic [N-1:0]  gnt_o;
  logic [IW-1:0] gnt_idx_o;

  rr_priority_arbiter #(
    .NUM_REQ (N),
    .IDX_W   (IW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Walk the request vector circularly starting at 'start'.
  // Returns the first set index, or -1 if no request is set.
  function automatic int circ_pick(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // Advance one clock. The model consumes the inputs as they are at the
  // edge. The DUT outputs are then compared on the following falling edge.
  task automatic step();
    int pick;
    @(posedge clk_i);
    if (rst_i) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
    end else if (!m_valid || ready_i) begin
      if (m_valid) begin
        $display("accept idx=%0d", m_idx);
        if (RR) m_ptr = (m_idx + 1) % N;
      end
      pick    = circ_pick(req_i, RR ? m_ptr : 0);
      m_valid = (pick >= 0);
      m_idx   = m_valid ? pick : 0;
    end
    @(negedge clk_i);
    check_eq("valid", {31'd0, valid_o}, {31'd0, m_valid});
    check_eq("gnt", {16'd0, gnt_o}, m_valid ? (32'd1 << m_idx) : 32'd0);
    check_eq("gnt_idx", {28'd0, gnt_idx_o}, m_idx);
  endtask

  // Directed check of the DUT grant against a hand-derived index.
  task automatic expect_grant(input string tag, input int idx);
    check_eq({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    check_eq({tag, "_idx"}, {28'd0, gnt_idx_o}, idx);
    check_eq({tag, "_gnt"}, {16'd0, gnt_o}, 32'd1 << idx);
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    check_eq({tag, "_gnt"}, {16'd0, gnt_o}, 32'd0);
    check_eq({tag, "_idx"}, {28'd0, gnt_idx_o}, 32'd0);
  endtask

  initial begin
    rst_i   = 1'b1;
    req_i   = 16'hFFFF;
    ready_i = 1'b1;

    // 1. Reset with all requests set, then idle.
    for (int c = 0; c < 2; c++) begin
      step();
      expect_idle("reset");
    end
    rst_i = 1'b0;
    req_i = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      expect_idle("idle");
    end

    // 2. Rotation with wrap. Grants alternate 4/12 with rotating priority,
    //    and stay at 4 with fixed priority.
    req_i = 16'h1010;
    for (int c = 0; c < 7; c++) begin
      step();
      expect_grant("rot", (RR && (c % 2 == 1)) ? 12 : 4);
    end

    // 3. Backpressure. The grant for idx 4 holds while req_i changes.
    ready_i = 1'b0;
    req_i   = 16'h0002;
    for (int c = 0; c < 5; c++) begin
      step();
      expect_grant("hold", 4);
    end
    ready_i = 1'b1;
    step();
    expect_grant("after_hold", 1);

    // 4. Top-index wrap from a fresh pointer.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    req_i = 16'h8001;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_grant("wrap", (RR && (c % 2 == 1)) ? 15 : 0);
    end

    // 5. Reset mid-handshake. A pending grant for idx 12 is dropped.
    req_i = 16'h1000;
    step();
    expect_grant("pre_rst", 12);
    ready_i = 1'b0;
    req_i   = 16'h1010;
    step();
    expect_grant("pre_rst_hold", 12);
    rst_i = 1'b1;
    step();
    expect_idle("mid_rst");
    rst_i   = 1'b0;
    ready_i = 1'b1;
    step();
    expect_grant("post_rst", 4);

    // 6. Random traffic against the model, with occasional resets.
    for (int c = 0; c < 1000; c++) begin
      int mode;
      mode    = $urandom_range(3);
      rst_i   = ($urandom_range(99) == 0);
      ready_i = ($urandom_range(3) != 0);
      case (mode)
        0:       req_i = '0;
        1:       req_i = N'(1) << $urandom_range(N - 1);
        default: req_i = N'($urandom);
      endcase
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
